// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_fetch_ctrl                                               |
// | Function : Instruction-fetch controller. Drives a combinational IMEM     |
// |            read port, captures data on the next edge, honours stall and  |
// |            redirect, and lends the port to a debug reader when the      |
// |            fetch path is idle or the debug request has starved.          |
// | Options  : IMEM_FAULT_CHECK_EN - misaligned / out-of-range fetch         |
// |            addresses raise a sticky Fault and park the FSM in HALT.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DBG_STARVE = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        DbgReq,
  input  logic [31:0] DbgAddr,
  output logic        DbgGrant,
  output logic        DbgValid,
  output logic [31:0] DbgData,
  output logic [31:0] MemAddress,
  input  logic [31:0] MemInstruction,
  output logic        IfValid,
  output logic [31:0] IfPC,
  output logic [31:0] IfInstruction,
  output logic        Fault
);

  // Starvation counter only needs to reach DBG_STARVE; keep at least 1 bit.
  localparam int unsigned c_cnt_w = (DBG_STARVE < 1) ? 1 : $clog2(DBG_STARVE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DEBUG = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t               r_state;
  logic [31:0]          r_pc;
  logic                 r_if_valid;
  logic [31:0]          r_if_pc;
  logic [31:0]          r_if_instr;
  logic                 r_dbg_grant;
  logic                 r_dbg_valid;
  logic [31:0]          r_dbg_data;
  logic                 r_fault;
  logic [c_cnt_w-1:0]   r_starve_cnt;

  logic                 w_starved;
  logic                 w_grant_now;
  logic                 w_cnt_at_max;
  logic                 w_fetch_fault;

  // The request has starved once this cycle would be its DBG_STARVE-th wait.
  assign w_starved    = (32'(r_starve_cnt) + 32'd1) >= 32'(DBG_STARVE);
  assign w_cnt_at_max = 32'(r_starve_cnt) >= 32'(DBG_STARVE);
  assign w_grant_now  = DbgReq && !Redirect && (Stall || w_starved);

`ifdef IMEM_FAULT_CHECK_EN
  localparam logic [32:0] c_imem_bytes = 33'(IMEM_WORDS) * 33'd4;
  // Fetch address must be word aligned and inside the memory.
  assign w_fetch_fault = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= c_imem_bytes);
`else
  // No checking: the memory wraps addresses through its own word index.
  assign w_fetch_fault = 1'b0;
`endif

  // Debug borrows the read port only during its granted cycle.
  assign MemAddress    = r_dbg_grant ? DbgAddr : r_pc;

  assign DbgGrant      = r_dbg_grant;
  assign DbgValid      = r_dbg_valid;
  assign DbgData       = r_dbg_data;
  assign IfValid       = r_if_valid;
  assign IfPC          = r_if_pc;
  assign IfInstruction = r_if_instr;
  assign Fault         = r_fault;

  // Fetch FSM: state, PC, fetch/debug output registers and starvation count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= 32'h0;
      r_dbg_grant  <= 1'b0;
      r_dbg_valid  <= 1'b0;
      r_dbg_data   <= 32'h0;
      r_fault      <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_dbg_grant <= 1'b0;
      r_dbg_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          if (Redirect) begin
            r_pc <= RedirectPC;
          end
        end

        ST_FETCH: begin
          if (Redirect) begin
            // Redirect beats everything; a pending debug request keeps aging.
            r_pc       <= RedirectPC;
            r_if_valid <= 1'b0;
            if (DbgReq && !w_cnt_at_max) begin
              r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
            end
          end else begin
            if (w_grant_now) begin
              r_state      <= ST_DEBUG;
              r_dbg_grant  <= 1'b1;
              r_starve_cnt <= '0;
            end else if (DbgReq) begin
              if (!w_cnt_at_max) begin
                r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
              end
            end else begin
              r_starve_cnt <= '0;
            end
            if (!Stall) begin
              if (w_fetch_fault) begin
                // The faulting word is never presented downstream.
                r_state     <= ST_HALT;
                r_fault     <= 1'b1;
                r_if_valid  <= 1'b0;
                r_dbg_grant <= 1'b0;
              end else begin
                r_if_instr <= MemInstruction;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + 32'd4;
              end
            end
          end
        end

        ST_DEBUG: begin
          // Memory returns the debug word; PC does not advance this cycle.
          r_dbg_valid <= 1'b1;
          r_dbg_data  <= MemInstruction;
          r_state     <= ST_FETCH;
          if (Redirect) begin
            r_pc       <= RedirectPC;
            r_if_valid <= 1'b0;
          end else if (!Stall) begin
            r_if_valid <= 1'b0;
          end
        end

        ST_HALT: begin
          r_if_valid <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 128, instruction memory depth in words.
REQ-003 SHALL have parameter DBG_STARVE, default 4, maximum cycles a pending debug request waits.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports, with clock and reset first:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Stall  in  1  decode cannot accept; hold fetch.
- Redirect  in  1  branch/jump taken.
- RedirectPC  in  32  new fetch address.
- DbgReq  in  1  debug read request, held until DbgGrant.
- DbgAddr  in  32  debug byte address.
- DbgGrant  out  1  debug owns memory this cycle.
- DbgValid  out  1  DbgData valid, 1-cycle pulse.
- DbgData  out  32  debug read result.
- MemAddress  out  32  combinational address to instruction memory.
- MemInstruction  in  32  combinational memory read data.
- IfValid  out  1  IfInstruction/IfPC valid.
- IfPC  out  32  PC of IfInstruction.
- IfInstruction  out  32  fetched word.
- Fault  out  1  sticky fetch fault.

Function
REQ-006 SHALL implement states IDLE, FETCH, DEBUG, HALT; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-007 SHALL drive MemAddress = PC, except DbgAddr when DbgGrant=1; read data SHALL be captured on the next rising edge (1-cycle latency).
REQ-008 In FETCH with Stall=0, Redirect=0, no grant: IfInstruction<=MemInstruction, IfPC<=PC, IfValid<=1, PC<=PC+4.
REQ-009 Stall=1 SHALL hold PC, IfPC, IfInstruction and IfValid unchanged.
REQ-010 Redirect=1 SHALL have top priority, including over Stall and debug: PC<=RedirectPC, IfValid<=0 next cycle (one bubble).
REQ-011 DbgGrant SHALL assert (state DEBUG, one cycle) when DbgReq=1, Redirect=0, and either Stall=1 or the request has waited DBG_STARVE cycles; PC SHALL hold and IfValid SHALL go 0 unless Stall=1.
REQ-012 DbgValid SHALL pulse one cycle after DbgGrant with DbgData = memory word at DbgAddr; starvation counter SHALL clear on grant.
REQ-013 Simultaneous Redirect and DbgReq: redirect wins; debug starvation count continues.
REQ-014 PC arithmetic SHALL be 32-bit modulo 2^32; MemAddress bits [1:0] SHALL be passed through unmodified.
REQ-015 HALT SHALL freeze PC, deassert IfValid and DbgGrant, and remain until reset.

Reset
REQ-016 Reset_n=0 SHALL immediately set PC=RESET_PC, state=IDLE, IfValid=0, IfPC=0, IfInstruction=0, DbgGrant=0, DbgValid=0, DbgData=0, Fault=0, starvation count=0.
REQ-017 Reset asserted mid-debug SHALL discard the pending debug read; no DbgValid SHALL follow.

Configuration
REQ-018 With IMEM_FAULT_CHECK_EN defined: fetch address with bits[1:0]!=0 or >= IMEM_WORDS*4 SHALL set Fault=1 and enter HALT on that edge; the faulting word is not presented.
REQ-019 Without IMEM_FAULT_CHECK_EN: Fault tied 0, HALT unreachable, out-of-range addresses wrap through the memory's word index.

Verification
REQ-020 Reset, RESET_PC=0, memory[i]=i*3, no stall -> IfValid rises 2 cycles after reset release; IfPC 0,4,8 with IfInstruction 0,3,6.
REQ-021 Stall=1 for 3 cycles at IfPC=8 -> IfPC=8, IfInstruction=6 held; resumes with IfPC=12, IfInstruction=9.
REQ-022 Redirect with RedirectPC=0x40 during Stall -> one cycle IfValid=0, then IfPC=0x40, IfInstruction=48.
REQ-023 DbgReq, DbgAddr=0x10, Stall=0 -> DbgGrant after 4 waiting cycles, bubble on IfValid, DbgValid next cycle with DbgData=12.
REQ-024 IMEM_FAULT_CHECK_EN defined, RedirectPC=0x200 -> Fault=1, IfValid=0, PC frozen until Reset_n low.
